picnic_challenge_extract: RTL and testbench
===========================================

# picnic_challenge_extract

Converts the 512-bit challenge digest from the hash stage into the stream of per-round ternary challenges (values 0, 1, 2) used by the Picnic response stage. The block requests a digest, scans it two bits at a time MSB-first, discards the pair `2'b11`, and emits each accepted pair with its round index. When a digest is exhausted before `T` challenges are produced, it hands that digest back upstream for re-hashing. It sits directly downstream of the hash stage: `hash_req` drives the hash stage's start, and `hash_done` is the hash stage's end flag.

## Interface
- `T`, default 219: number of challenges to produce, 1..1023.
- `CNT_W`, default 10: width of the round index.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins an extraction. Honoured only in IDLE.
- `hash_req`  out  1  level request to the hash stage (connects to its start).
- `rehash`  out  1  qualifies `hash_req`: 0 = initial challenge hash, 1 = hash of `rehash_data`.
- `rehash_data`  out  512  digest currently held; stable whenever `hash_req`=1.
- `hash_done`  in  1  hash stage end flag (level).
- `digest`  in  512  hash stage result; valid while `hash_done`=1.
- `ch_valid`  out  1  challenge available.
- `ch_value`  out  2  challenge value, never `2'b11`.
- `ch_index`  out  CNT_W  round index, 0..T-1.
- `ch_ready`  in  1  consumer accepts.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the T-th challenge is accepted.

## Operation
- **States:** IDLE, REQ, SCAN, DONE.
- **IDLE:**
  - On `start`: round counter `rc`=0, `rehash`=0, go to REQ.
  - All other inputs are ignored.
- **REQ:**
  - `hash_req`=1.
  - Entry into REQ is gated on `hash_done`=0. If `hash_done` is still high from the previous run, the block holds `hash_req`=0 in REQ until `hash_done` is low.
  - On a cycle with `hash_req`=1 and `hash_done`=1: load `dreg` from `digest`, set pair pointer `pp`=0, go to SCAN.
- **SCAN:**
  - Current pair: `pair = dreg[511-2*pp -: 2]`.
  - `ch_valid = (pair != 3)`. This output is combinational from the registered state.
  - `ch_value = pair`, `ch_index = rc`.
  - If `pair == 3`: `pp` increments (discard), with no dependence on `ch_ready`.
  - If `ch_valid && ch_ready`: `rc` and `pp` both increment.
  - If `ch_valid && !ch_ready`: all state is held, and `ch_value`/`ch_index` stay stable.
- **Leaving SCAN**, evaluated in the same cycle as the advance:
  - If the accepted challenge has `rc == T-1`: go to DONE. This takes priority even when `pp==255`.
  - Else if `pp == 255` is being consumed (accepted or discarded): `rehash`=1, go to REQ. `rehash_data` = `dreg`, which is unchanged until the new digest is loaded.
- **DONE:** `done`=1 for one cycle, then IDLE. `dreg` is retained.
- `start` outside IDLE is ignored.
- **Reset (any time, including mid-SCAN or mid-REQ):**
  - State goes to IDLE.
  - All outputs and counters go to 0, and `dreg` goes to 0.
  - Any in-flight upstream hash is abandoned.
- **Arithmetic:** `pp` is 8 bits, modulo 256. Wrap happens only via the REQ path. `rc` never exceeds T-1.

## Timing
- **Reset values:** `hash_req`=0, `rehash`=0, `rehash_data`=0, `ch_valid`=0, `ch_value`=0, `ch_index`=0, `busy`=0, `done`=0.
- `start` sampled at edge E: `busy`=1 and `hash_req`=1 from E+1 (if `hash_done`=0).
- Capture edge C (`hash_req`&&`hash_done`): `hash_req`=0 from C+1, SCAN from C+1, first `ch_valid` possible at C+1.
- **Throughput:** one pair examined per cycle. One challenge per cycle under continuous `ch_ready`.
- **Digest lifetime:** each digest occupies at most 256 SCAN cycles plus the stall cycles caused by `ch_ready`=0.
- Final acceptance at edge F: `done`=1 during F+1, `busy`=1 during F+1, IDLE (`busy`=0) from F+2.

## Test plan
- **All-zero digest, T=4, `ch_ready`=1:** start, `hash_done` 3 cycles later → four beats, value 0, index 0..3, on consecutive cycles; `done` one cycle after the last beat; `hash_req` never re-asserted.
- **Digest MSBs `11 11 01 10 00`…, T=3:** beats (1,0), (2,1), (0,2); first `ch_valid` two cycles after the SCAN entry cycle.
- **All-ones first digest, T=2:** 256 discard cycles, then `hash_req`=1, `rehash`=1, `rehash_data`=all-ones. Second digest all-zero → beats index 0, 1, then `done`.
- **Backpressure:** `ch_ready` low for 5 cycles on beat 1 → `ch_valid`, `ch_value`, `ch_index` held constant; no skipped or duplicated index.
- **Boundary:** digest with pairs 0..254 = `11` and pair 255 = `01`, T=1 → single beat (1,0), then DONE, no rehash. Same digest with T=2 → rehash after that beat.
- **Reset mid-SCAN:** assert `reset` low at round 7 → all outputs 0 asynchronously. After release, a new start with a fresh digest restarts at index 0.

Source files
------------

// File: rtl/picnic_challenge_extract_if.sv
// Hash-stage and challenge-stream signals for picnic_challenge_extract.
// master is the extractor side; slave is the hash stage / consumer side.
interface picnic_challenge_extract_if #(
  parameter int CNT_W = 10
);
  logic             hash_req;
  logic             rehash;
  logic [511:0]     rehash_data;
  logic             hash_done;
  logic [511:0]     digest;
  logic             ch_valid;
  logic [1:0]       ch_value;
  logic [CNT_W-1:0] ch_index;
  logic             ch_ready;

  modport master (
    output hash_req, rehash, rehash_data, ch_valid, ch_value, ch_index,
    input  hash_done, digest, ch_ready
  );

  modport slave (
    input  hash_req, rehash, rehash_data, ch_valid, ch_value, ch_index,
    output hash_done, digest, ch_ready
  );
endinterface

// File: rtl/picnic_challenge_extract.sv
// Turns 512-bit challenge digests into T ternary challenges, scanning 2-bit
// pairs MSB-first, discarding 2'b11, and requesting a rehash when a digest runs dry.
module picnic_challenge_extract #(
  parameter int T     = 219,
  parameter int CNT_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  picnic_challenge_extract_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, SCAN, DONE} state_t;

  state_t           state;
  logic [511:0]     dreg;
  logic [7:0]       pp;
  logic [CNT_W-1:0] rc;
  logic             hash_req_r;
  logic             rehash_r;
  logic             done_r;

  logic [1:0]       pair;
  logic             in_scan;
  logic             discard;
  logic             accept;
  logic             last_pair;
  logic             last_round;

  // Bit index of pair pp's MSB is 511-2*pp = {~pp,1}; its LSB is {~pp,0}.
  assign pair       = {dreg[{~pp, 1'b1}], dreg[{~pp, 1'b0}]};
  assign in_scan    = (state == SCAN);
  assign discard    = in_scan && (pair == 2'b11);
  assign accept     = bus.ch_valid && bus.ch_ready;
  assign last_pair  = (pp == 8'hFF);
  assign last_round = (rc == CNT_W'(T - 1));

  assign bus.ch_valid    = in_scan && (pair != 2'b11);
  assign bus.ch_value    = in_scan ? pair : 2'b00;
  assign bus.ch_index    = in_scan ? rc : '0;
  assign bus.hash_req    = hash_req_r;
  assign bus.rehash      = rehash_r;
  assign bus.rehash_data = dreg;
  assign busy            = (state != IDLE);
  assign done            = done_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dreg       <= '0;
      pp         <= '0;
      rc         <= '0;
      hash_req_r <= 1'b0;
      rehash_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rc         <= '0;
            rehash_r   <= 1'b0;
            hash_req_r <= !bus.hash_done;
            state      <= REQ;
          end
        end
        REQ: begin
          // A hash_done left high by the previous run must drop before requesting.
          if (hash_req_r && bus.hash_done) begin
            dreg       <= bus.digest;
            pp         <= '0;
            hash_req_r <= 1'b0;
            state      <= SCAN;
          end else begin
            hash_req_r <= !bus.hash_done;
          end
        end
        SCAN: begin
          if (accept && last_round) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else if (discard || accept) begin
            pp <= pp + 8'd1;
            if (accept) rc <= rc + 1'b1;
            if (last_pair) begin
              rehash_r   <= 1'b1;
              hash_req_r <= !bus.hash_done;
              state      <= REQ;
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picnic_challenge_extract.sv
// Directed bench for picnic_challenge_extract: a hash-stage model feeds digests,
// expected beats go into a queue and a monitor checks every accepted beat.
module tb_picnic_challenge_extract;
  localparam int T     = 4;
  localparam int CNT_W = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  picnic_challenge_extract_if #(.CNT_W(CNT_W)) bif ();

  picnic_challenge_extract #(.T(T), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       v;
    logic [CNT_W-1:0] i;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    done_pending = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input int i);
    beat_t b;
    b.v = v;
    b.i = i[CNT_W-1:0];
    exp_q.push_back(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Hash-stage model: wait for the request, delay, present the digest until captured.
  task automatic provide(input logic [511:0] d, input int delay);
    int k;
    k = 0;
    while (!bif.hash_req && k < 1000) begin
      tick(1);
      k++;
    end
    check("hash_req_seen", 512'(bif.hash_req), 512'd1);
    if (delay > 0) tick(delay);
    bif.hash_done = 1'b1;
    bif.digest    = d;
    k = 0;
    while (bif.hash_req && k < 10) begin
      tick(1);
      k++;
    end
    check("capture_latency", 512'(k), 512'd1);
    bif.hash_done = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    int cyc;
    int nreq;
    cyc  = 0;
    nreq = 0;
    while (!done && cyc < 3000) begin
      tick(1);
      cyc++;
      if (bif.hash_req) nreq++;
    end
    check({name, "_done_cycles"}, 512'(cyc), 512'(exp_cyc));
    check({name, "_no_rehash_req"}, 512'(nreq), 512'd0);
    check({name, "_busy_in_done"}, 512'(busy), 512'd1);
    tick(1);
    check({name, "_done_cleared"}, 512'(done), 512'd0);
    check({name, "_idle"}, 512'(busy), 512'd0);
    check({name, "_queue_empty"}, 512'(exp_q.size()), 512'd0);
  endtask

  task automatic wait_rehash(input int exp_cyc, input logic [511:0] d, input string name);
    int cyc;
    cyc = 0;
    while (!bif.hash_req && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    check({name, "_rehash_cycles"}, 512'(cyc), 512'(exp_cyc));
    check({name, "_rehash_flag"}, 512'(bif.rehash), 512'd1);
    check({name, "_rehash_data"}, bif.rehash_data, d);
    check({name, "_busy"}, 512'(busy), 512'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_hash_req"}, 512'(bif.hash_req), 512'd0);
    check({name, "_rehash"}, 512'(bif.rehash), 512'd0);
    check({name, "_rehash_data"}, bif.rehash_data, 512'd0);
    check({name, "_ch_valid"}, 512'(bif.ch_valid), 512'd0);
    check({name, "_ch_value"}, 512'(bif.ch_value), 512'd0);
    check({name, "_ch_index"}, 512'(bif.ch_index), 512'd0);
    check({name, "_busy"}, 512'(busy), 512'd0);
    check({name, "_done"}, 512'(done), 512'd0);
  endtask

  // Scoreboard monitor: compare every accepted beat against the queue head.
  always @(negedge clk) begin
    if (reset) begin
      if (done_pending) begin
        check("done_after_last_beat", 512'(done), 512'd1);
        done_pending = 1'b0;
      end
      if (bif.ch_valid) check("ch_value_not_3", 512'(bif.ch_value == 2'b11), 512'd0);
      if (bif.ch_valid && bif.ch_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got value %0d index %0d, expected no beat",
                   bif.ch_value, bif.ch_index);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_value", 512'(bif.ch_value), 512'(e.v));
          check("beat_index", 512'(bif.ch_index), 512'(e.i));
          if (e.i == CNT_W'(T - 1)) done_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [511:0] ZERO   = '0;
  localparam logic [511:0] ONES   = '1;
  localparam logic [511:0] D_B    = {8'hF6, 504'h0};
  localparam logic [511:0] D_BP   = {8'h61, 504'h0};
  localparam logic [511:0] D_E1   = {{504{1'b1}}, 8'h55};
  localparam logic [511:0] D_E2   = {{510{1'b1}}, 2'b01};

  initial begin
    bif.hash_done = 1'b0;
    bif.digest    = '0;
    bif.ch_ready  = 1'b1;

    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    tick(2);
    reset = 1'b1;
    tick(1);

    // All-zero digest: four beats on consecutive cycles
    for (int i = 0; i < T; i++) push(2'd0, i);
    pulse_start();
    check("a_busy_after_start", 512'(busy), 512'd1);
    check("a_hash_req_after_start", 512'(bif.hash_req), 512'd1);
    check("a_rehash_initial", 512'(bif.rehash), 512'd0);
    provide(ZERO, 3);
    wait_done(4, "a");

    // Leading 11 11 discarded; beats (1,0) (2,1) (0,2) (0,3)
    push(2'd1, 0); push(2'd2, 1); push(2'd0, 2); push(2'd0, 3);
    pulse_start();
    provide(D_B, 1);
    check("b_valid_c1", 512'(bif.ch_valid), 512'd0);
    tick(1);
    check("b_valid_c2", 512'(bif.ch_valid), 512'd0);
    tick(1);
    check("b_valid_c3", 512'(bif.ch_valid), 512'd1);
    wait_done(4, "b");

    // All-ones digest forces a rehash, then a zero digest finishes
    for (int i = 0; i < T; i++) push(2'd0, i);
    pulse_start();
    provide(ONES, 2);
    wait_rehash(256, ONES, "c");
    provide(ZERO, 1);
    wait_done(4, "c");

    // Backpressure on beat 1 for five cycles
    push(2'd1, 0); push(2'd2, 1); push(2'd0, 2); push(2'd1, 3);
    pulse_start();
    provide(D_BP, 0);
    tick(1);
    bif.ch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("d_hold_valid", 512'(bif.ch_valid), 512'd1);
      check("d_hold_value", 512'(bif.ch_value), 512'd2);
      check("d_hold_index", 512'(bif.ch_index), 512'd1);
      tick(1);
    end
    bif.ch_ready = 1'b1;
    wait_done(3, "d");

    // Final round lands on pair 255: done wins over rehash
    for (int i = 0; i < T; i++) push(2'd1, i);
    pulse_start();
    provide(D_E1, 1);
    wait_done(256, "e1");

    // Non-final beat on pair 255: rehash follows the beat
    push(2'd1, 0);
    pulse_start();
    provide(D_E2, 0);
    wait_rehash(256, D_E2, "e2");
    push(2'd0, 1); push(2'd0, 2); push(2'd0, 3);
    provide(ZERO, 0);
    wait_done(3, "e2");

    // Reset in the middle of SCAN, then a gated restart
    push(2'd0, 0); push(2'd0, 1);
    pulse_start();
    provide(ZERO, 0);
    tick(2);
    #2 reset = 1'b0;
    exp_q.delete();
    done_pending = 1'b0;
    #1 check_all_zero("f_reset_mid_scan");
    tick(1);
    reset = 1'b1;
    tick(1);
    bif.hash_done = 1'b1;
    push(2'd1, 0); push(2'd2, 1); push(2'd0, 2); push(2'd1, 3);
    pulse_start();
    check("f_busy", 512'(busy), 512'd1);
    check("f_req_gated_1", 512'(bif.hash_req), 512'd0);
    tick(1);
    check("f_req_gated_2", 512'(bif.hash_req), 512'd0);
    bif.hash_done = 1'b0;
    tick(1);
    check("f_req_after_gate", 512'(bif.hash_req), 512'd1);
    provide(D_BP, 0);
    wait_done(4, "f");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
